// File: rtl/clipper_timebase_ctrl.sv
// Clipper timebase controller: controlled and free-running 64-bit ns
// timebases, load handshake, periodic tick and one-shot alarm.
module clipper_timebase_ctrl #(
   parameter int unsigned INC_NS     = 8,
   parameter int unsigned ACCEL_MULT = 16,
   parameter int unsigned TICK_LOG2  = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_req,
   input  logic [63:0] load_time,
   output logic        load_ack,
   input  logic        accel,
   input  logic        freeze,
   input  logic        alarm_arm,
   input  logic [63:0] alarm_time,
   input  logic        alarm_clr,
   output logic [63:0] timebase,
   output logic [63:0] free_run_timebase,
   output logic        tick,
   output logic [1:0]  alarm_state,
   output logic        alarm_irq
);

   localparam logic [63:0] STEP_N = 64'(INC_NS);
   localparam logic [63:0] STEP_A = 64'(INC_NS * ACCEL_MULT);

   typedef enum logic [1:0] {
      LD_IDLE  = 2'd0,
      LD_APPLY = 2'd1,
      LD_WAIT  = 2'd2
   } ld_state_e;

   typedef enum logic [1:0] {
      AL_IDLE  = 2'd0,
      AL_ARMED = 2'd1,
      AL_FIRED = 2'd2
   } al_state_e;

   ld_state_e   ld_q, ld_d;
   al_state_e   al_q, al_d;
   logic [63:0] tb_q, tb_d;
   logic [63:0] fr_q, fr_d;
   logic [63:0] at_q, at_d;
   logic        ack_q, ack_d;
   logic        cross_q, cross_d;
   logic        tick_q;
   logic        irq_q, irq_d;
   logic        do_load;

   // Load handshake: the load itself happens on the edge that leaves IDLE
   always_comb begin
      ld_d    = ld_q;
      ack_d   = 1'b0;
      do_load = 1'b0;
      unique case (ld_q)
         LD_IDLE: begin
            if (load_req) begin
               do_load = 1'b1;
               ld_d    = LD_APPLY;
            end
         end
         LD_APPLY: begin
            ack_d = 1'b1;
            ld_d  = LD_WAIT;
         end
         LD_WAIT: begin
            if (!load_req) ld_d = LD_IDLE;
         end
         default: ld_d = LD_IDLE;
      endcase
   end

   always_comb begin
      tb_d = tb_q;
      if (do_load) begin
         tb_d = load_time;
      end else if (freeze) begin
         tb_d = tb_q;
      end else if (accel) begin
         tb_d = tb_q + STEP_A;
      end else begin
         tb_d = tb_q + STEP_N;
      end
      fr_d = fr_q + STEP_N;
      // Period crossing is flagged now and shown as tick one edge later
      cross_d = !do_load &&
                (tb_d[63:TICK_LOG2] != tb_q[63:TICK_LOG2]);
   end

   always_comb begin
      al_d  = al_q;
      at_d  = at_q;
      irq_d = 1'b0;
      if (alarm_arm) begin
         al_d = AL_ARMED;
         at_d = alarm_time;
      end else begin
         unique case (al_q)
            AL_ARMED: begin
               if (alarm_clr) begin
                  al_d = AL_IDLE;
               end else if (tb_q >= at_q) begin
                  al_d  = AL_FIRED;
                  irq_d = 1'b1;
               end
            end
            AL_FIRED: begin
               if (alarm_clr) al_d = AL_IDLE;
            end
            default: al_d = al_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ld_q    <= LD_IDLE;
         al_q    <= AL_IDLE;
         tb_q    <= '0;
         fr_q    <= '0;
         at_q    <= '0;
         ack_q   <= 1'b0;
         cross_q <= 1'b0;
         tick_q  <= 1'b0;
         irq_q   <= 1'b0;
      end else begin
         ld_q    <= ld_d;
         al_q    <= al_d;
         tb_q    <= tb_d;
         fr_q    <= fr_d;
         at_q    <= at_d;
         ack_q   <= ack_d;
         cross_q <= cross_d;
         tick_q  <= cross_q;
         irq_q   <= irq_d;
      end
   end

   assign load_ack          = ack_q;
   assign timebase          = tb_q;
   assign free_run_timebase = fr_q;
   assign tick              = tick_q;
   assign alarm_state       = al_q;
   assign alarm_irq         = irq_q;

endmodule
